// File: rtl/inst_encoder_if.sv
// Request/response bundle for the instruction encoder: request fields in,
// encoded word and error status out.
interface inst_encoder_if #(
    parameter int unsigned Width = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       fmt;
    logic [6:0]       opcode;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [Width-1:0] imm;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] inst;
    logic             err;
    logic [7:0]       err_cnt;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, inst, err, err_cnt
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, inst, err, err_cnt
    );
endinterface

// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs format-specific fields into a 32-bit word,
// replaces out-of-range requests with a NOP, and buffers results in a 2-deep FIFO.
module inst_encoder #(
    parameter int unsigned Width = 32
) (
    input logic          clk,
    input logic          rst_n,
    inst_encoder_if.slave bus
);
    localparam int unsigned CntW    = 2;
    localparam int unsigned ErrCntW = 8;
    localparam logic [Width-1:0] Nop = Width'(32'h0000_0013);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef struct packed {
        logic             err;
        logic [Width-1:0] inst;
    } entry_t;

    entry_t             ent0_q, ent0_d;
    entry_t             ent1_q, ent1_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

    logic             in_ready_c;
    logic             push_c;
    logic             pop_c;
    logic [CntW-1:0]  wr_idx_c;
    logic [Width-1:0] enc_inst_c;
    logic             enc_legal_c;
    logic             fits12_c;
    logic             fits13_c;
    logic             fits21_c;
    entry_t           new_ent_c;

    // Sign-extension checks: upper bits must all equal the field's sign bit.
    assign fits12_c = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
    assign fits13_c = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
    assign fits21_c = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

    always_comb begin
        enc_inst_c  = Nop;
        enc_legal_c = 1'b0;
        case (fmt_e'(bus.fmt))
            FMT_R: begin
                enc_inst_c  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_legal_c = 1'b1;
            end
            FMT_I: begin
                enc_inst_c  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                enc_legal_c = fits12_c;
            end
            FMT_S: begin
                enc_inst_c  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:0], bus.opcode};
                enc_legal_c = fits12_c;
            end
            FMT_B: begin
                enc_inst_c  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                               bus.imm[4:1], bus.imm[11], bus.opcode};
                enc_legal_c = fits13_c & ~bus.imm[0];
            end
            FMT_U: begin
                enc_inst_c  = {bus.imm[31:12], bus.rd, bus.opcode};
                enc_legal_c = ~(|bus.imm[11:0]);
            end
            FMT_J: begin
                enc_inst_c  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                               bus.rd, bus.opcode};
                enc_legal_c = fits21_c & ~bus.imm[0];
            end
            default: begin
                enc_inst_c  = Nop;
                enc_legal_c = 1'b0;
            end
        endcase
    end

    assign new_ent_c = enc_legal_c ? entry_t'{err: 1'b0, inst: enc_inst_c}
                                   : entry_t'{err: 1'b1, inst: Nop};

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign in_ready_c = (count_q != CntW'(2)) | bus.out_ready;
    assign push_c     = bus.in_valid & in_ready_c;
    assign pop_c      = (count_q != '0) & bus.out_ready;
    assign wr_idx_c   = count_q - CntW'(pop_c);

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_comb begin
        ent0_d    = ent0_q;
        ent1_d    = ent1_q;
        count_d   = count_q + CntW'(push_c) - CntW'(pop_c);
        err_cnt_d = err_cnt_q;
        if (pop_c) begin
            ent0_d = ent1_q;
        end
        if (push_c) begin
            if (wr_idx_c == '0) begin
                ent0_d = new_ent_c;
            end else begin
                ent1_d = new_ent_c;
            end
            if (!enc_legal_c && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ErrCntW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q    <= '0;
            ent1_q    <= '0;
            count_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            ent0_q    <= ent0_d;
            ent1_q    <= ent1_d;
            count_q   <= count_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (count_q != '0);
    assign bus.inst      = ent0_q.inst;
    assign bus.err       = ent0_q.err;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Directed and randomized-legal checks for inst_encoder: encodings, range rules,
// FIFO backpressure, error counter saturation and asynchronous reset.
module tb_inst_encoder;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    int   exp_cnt;

    inst_encoder_if #(.Width(32)) bus ();

    inst_encoder #(.Width(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_v,
                           input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        bus.fmt      = f;
        bus.opcode   = op;
        bus.rd       = rd_v;
        bus.rs1      = rs1_v;
        bus.rs2      = rs2_v;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.imm      = im;
        bus.in_valid = 1'b1;
    endtask

    // Present a request, wait (bounded) for in_ready, then let one edge accept it.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd_v,
                        input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        int k;
        set_req(f, op, rd_v, rs1_v, rs2_v, f3, f7, im);
        k = 0;
        while (!bus.in_ready && k < 100) begin
            tick();
            k++;
        end
        if (!bus.in_ready) check("send_ready_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic bump_cnt();
        exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    endtask

    // One directed vector with out_ready=1: word visible right after accept, popped next edge.
    task automatic vec(input string tag, input logic [2:0] f, input logic [6:0] op,
                       input logic [4:0] rd_v, input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                       input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                       input logic [31:0] exp_inst, input logic exp_err);
        send(f, op, rd_v, rs1_v, rs2_v, f3, f7, im);
        if (exp_err) bump_cnt();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_inst"}, bus.inst, exp_inst);
        check({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        check({tag, "_errcnt"}, 32'(bus.err_cnt), 32'(exp_cnt));
        tick();
    endtask

    logic [2:0]  r_fmt;
    logic [6:0]  r_op;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [2:0]  r_f3;
    logic [6:0]  r_f7;
    logic [31:0] r_imm;
    logic [31:0] r_raw;
    logic [31:0] d_imm;
    logic [31:0] w;

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        exp_cnt      = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        bus.in_valid = 1'b0;
        #12;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        bus.out_ready = 1'b1;
        vec("i_neg1", 3'd1, 7'b0010011, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0);
        check("empty_after_pop", 32'(bus.out_valid), 32'd0);
        vec("b_8", 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 32'h0020_8463, 1'b0);
        vec("b_7", 3'd3, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 32'h0000_0013, 1'b1);
        vec("j_neg4", 3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1'b0);
        vec("u_basic", 3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        vec("r_sub", 3'd0, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 1'b0);
        vec("s_neg8", 3'd2, 7'b0100011, 5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFE53_2C23, 1'b0);
        vec("i_2047", 3'd1, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF0_0013, 1'b0);
        vec("i_2048", 3'd1, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0000_0013, 1'b1);
        vec("i_m2048", 3'd1, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0);
        vec("b_m4096", 3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000, 32'h8000_0063, 1'b0);
        vec("b_4096", 3'd3, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 32'h0000_0013, 1'b1);
        vec("u_lowbit", 3'd4, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
        vec("j_2pow20", 3'd5, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000, 32'h0000_0013, 1'b1);
        vec("fmt6", 3'd6, 7'b0110011, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 32'h0000_0013, 1'b1);

        // Backpressure: two fill the FIFO, third waits until the first pop.
        bus.out_ready = 1'b0;
        set_req(3'd4, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000);
        tick();
        set_req(3'd4, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_2000);
        tick();
        set_req(3'd4, 7'b0110111, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_3000);
        check("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_head_a", bus.inst, 32'h0000_10B7);
        bus.out_ready = 1'b1;
        #1;
        check("bp_pop_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check("bp_head_b", bus.inst, 32'h0000_2137);
        tick();
        check("bp_head_c", bus.inst, 32'h0000_31B7);
        check("bp_valid_c", 32'(bus.out_valid), 32'd1);
        tick();
        check("bp_drained", 32'(bus.out_valid), 32'd0);

        // Saturating error counter.
        for (int i = 0; i < 300; i++) begin
            send(3'd7, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
            bump_cnt();
        end
        tick();
        check("err_cnt_sat", 32'(bus.err_cnt), 32'(exp_cnt));
        check("err_cnt_sat_255", 32'(bus.err_cnt), 32'd255);

        // Mid-stream reset with two entries queued.
        bus.out_ready = 1'b0;
        send(3'd1, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5);
        send(3'd1, 7'b0010011, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd6);
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("mid_rst_inst", bus.inst, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("after_rst_valid", 32'(bus.out_valid), 32'd0);
        check("after_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Random legal requests, decoded field-wise.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r_fmt = 3'($urandom_range(0, 5));
            r_op  = 7'($urandom);
            r_rd  = 5'($urandom);
            r_rs1 = 5'($urandom);
            r_rs2 = 5'($urandom);
            r_f3  = 3'($urandom);
            r_f7  = 7'($urandom);
            r_raw = $urandom;
            case (r_fmt)
                3'd1, 3'd2: r_imm = {{20{r_raw[11]}}, r_raw[11:0]};
                3'd3:       r_imm = {{19{r_raw[12]}}, r_raw[12:1], 1'b0};
                3'd4:       r_imm = {r_raw[31:12], 12'd0};
                3'd5:       r_imm = {{11{r_raw[20]}}, r_raw[20:1], 1'b0};
                default:    r_imm = r_raw;
            endcase
            send(r_fmt, r_op, r_rd, r_rs1, r_rs2, r_f3, r_f7, r_imm);
            w = bus.inst;
            check("rnd_valid", 32'(bus.out_valid), 32'd1);
            check("rnd_err", 32'(bus.err), 32'd0);
            check("rnd_opcode", 32'(w[6:0]), 32'(r_op));
            if (r_fmt != 3'd2 && r_fmt != 3'd3) check("rnd_rd", 32'(w[11:7]), 32'(r_rd));
            if (r_fmt <= 3'd3) begin
                check("rnd_rs1", 32'(w[19:15]), 32'(r_rs1));
                check("rnd_funct3", 32'(w[14:12]), 32'(r_f3));
            end
            if (r_fmt == 3'd0 || r_fmt == 3'd2 || r_fmt == 3'd3) check("rnd_rs2", 32'(w[24:20]), 32'(r_rs2));
            if (r_fmt == 3'd0) check("rnd_funct7", 32'(w[31:25]), 32'(r_f7));
            case (r_fmt)
                3'd1:    d_imm = {{20{w[31]}}, w[31:20]};
                3'd2:    d_imm = {{20{w[31]}}, w[31:25], w[11:7]};
                3'd3:    d_imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
                3'd4:    d_imm = {w[31:12], 12'd0};
                3'd5:    d_imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
                default: d_imm = 32'd0;
            endcase
            if (r_fmt != 3'd0) check("rnd_imm", d_imm, r_imm);
            tick();
        end
        check("rnd_err_cnt", 32'(bus.err_cnt), 32'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have parameter Width, default 32, giving the instruction and immediate width; only 32 is supported.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 fmt  input  3  instruction format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
REQ-008 opcode  input  7  opcode, placed verbatim in inst[6:0].
REQ-009 rd, rs1, rs2  input  5 each  register fields.
REQ-010 funct3  input  3; funct7  input  7  function fields.
REQ-011 imm  input  Width  signed byte-offset or value immediate.
REQ-012 out_valid  output  1  encoded word valid.
REQ-013 out_ready  input  1  consumer accepts the word.
REQ-014 inst  output  Width  encoded instruction.
REQ-015 err  output  1  entry was illegal and was replaced by a NOP.
REQ-016 err_cnt  output  8  saturating count of illegal requests accepted.

Function
REQ-017 Accept: a request is accepted on a rising edge with in_valid=1 and in_ready=1; push: an accepted request is encoded combinationally and written into a 2-entry FIFO in the same edge.
REQ-018 in_ready SHALL be 1 when FIFO count<2, or when count==2 and out_ready=1 (pop and push in the same cycle).
REQ-019 out_valid SHALL be 1 when count>0; inst and err SHALL come from the FIFO head; pop occurs on out_valid=1 and out_ready=1.
REQ-020 Latency: a request accepted at edge N into an empty FIFO SHALL present out_valid=1 after edge N; there is no combinational path from in_* to out_*.
REQ-021 Encoding: R = {funct7,rs2,rs1,funct3,rd,opcode}; I = {imm[11:0],rs1,funct3,rd,opcode}; S = {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}; B = {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}; U = {imm[31:12],rd,opcode}; J = {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-022 Range rules, with imm as two's complement: I and S require -2048..2047; B requires -4096..4094 and imm[0]=0; J requires -1048576..1048574 and imm[0]=0; U requires imm[11:0]=0; R ignores imm.
REQ-023 An illegal request (fmt 6/7 or a range violation) SHALL push inst=32'h00000013 with err=1; a legal request SHALL push err=0.
REQ-024 err_cnt SHALL increment on each accepted illegal request and hold at 255.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-026 Pop with count==0 and push with in_ready=0 SHALL be ignored, with no state change.
REQ-027 Inputs SHALL be ignored when in_valid=0.

Reset
REQ-028 While rst_n=0, regardless of clk: FIFO count=0, out_valid=0, inst=0, err=0, err_cnt=0, and in_ready=1 after reset is released.
REQ-029 Reset asserted mid-stream SHALL discard all FIFO contents immediately; no partial word is emitted after release.

Verification
REQ-030 I-type, opcode 0010011, rd=1, rs1=2, funct3=0, imm=-1 -> inst=32'hFFF10093, err=0, one cycle after accept.
REQ-031 B-type, opcode 1100011, rs1=1, rs2=2, funct3=0, imm=8 -> inst=32'h00208463; the same request with imm=7 -> inst=32'h00000013, err=1, err_cnt increments by 1.
REQ-032 J-type, opcode 1101111, rd=1, imm=-4 -> inst=32'hFFDFF0EF; U-type with imm=32'h12345000, rd=5, opcode 0110111 -> inst=32'h123452B7.
REQ-033 Backpressure: out_ready=0 with 3 back-to-back requests -> in_ready=0 after 2 are accepted; out_ready=1 -> words drain in order, and the 3rd is accepted in the same cycle as the first pop.
REQ-034 Issue 300 illegal fmt=7 requests -> err_cnt=255; assert rst_n=0 with 2 entries queued -> out_valid=0 and err_cnt=0 immediately.
REQ-035 Random legal requests -> decoding each inst field-wise returns the original immediate, register fields, and funct fields.
